// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-lane data memory: access sizes, FSM states
// and the lane-mask / alignment helpers used by the top level.
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_R = 2'b11;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // Byte lanes touched by an aligned access of the given size at the given lane.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_B:    lane_mask = 4'b0001 << lane;
      SZ_H:    lane_mask = lane[1] ? 4'b1100 : 4'b0011;
      SZ_W:    lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    is_misaligned = (size == SZ_R) ||
                    ((size == SZ_H) && lane[0]) ||
                    ((size == SZ_W) && (lane != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_bytelane_if.sv
// Access bus between the CPU datapath and the data memory.
interface dmem_bytelane_if #(
  parameter int ADDR_W = 7
) ();

  logic              ena;
  logic              wena;
  logic [1:0]        size;
  logic              sign_ext;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       data_in;
  logic [31:0]       data_out;
  logic              misalign;
  logic              busy;

  modport master (
    output ena, wena, size, sign_ext, addr, data_in,
    input  data_out, misalign, busy
  );

  modport slave (
    input  ena, wena, size, sign_ext, addr, data_in,
    output data_out, misalign, busy
  );

endinterface

// File: rtl/dmem_load_align.sv
// Selects the addressed byte/half/word from a memory word and right-aligns it
// with sign or zero extension.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word[{lane, 3'b000} +: 8];
    half_v = lane[1] ? word[31:16] : word[15:0];
    result = '0;
    case (size)
      SZ_B:    result = {{24{sign_ext & byte_v[7]}}, byte_v};
      SZ_H:    result = {{16{sign_ext & half_v[15]}}, half_v};
      SZ_W:    result = word;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/dmem_bytelane.sv
// Byte-lane data memory: four byte banks, sub-word stores with lane enables,
// extended sub-word loads, misalignment flag and a post-reset zero-fill sweep.
module dmem_bytelane
  import dmem_pkg::*;
#(
  parameter int DEPTH     = 32,
  parameter int ADDR_W    = 7,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_bytelane_if.slave bus
);

  localparam int IDX_W = ADDR_W - 2;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  init_cnt_q, init_cnt_d;
  logic              busy;
  logic [IDX_W-1:0]  word_idx;
  logic [1:0]        lane;
  logic              misalign;
  logic              wr_en;
  logic              rd_en;
  logic [3:0]        mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [31:0]       mem_wd;
  logic [31:0]       rd_word;
  logic [31:0]       aligned;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == ST_INIT) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == IDX_W'(DEPTH - 1)) state_d = ST_READY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= INIT_ZERO ? ST_INIT : ST_READY;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  assign busy     = (state_q == ST_INIT);
  assign word_idx = bus.addr[ADDR_W-1:2];
  assign lane     = bus.addr[1:0];
  assign misalign = bus.ena & ~busy & is_misaligned(bus.size, lane);
  assign wr_en    = bus.ena & bus.wena & ~busy & ~misalign;
  assign rd_en    = bus.ena & ~bus.wena & ~busy & ~misalign;

  // The sweep owns the write port while busy; store data is replicated so each
  // enabled lane picks its bytes from the matching position.
  always_comb begin
    mem_we  = 4'b0000;
    mem_idx = word_idx;
    mem_wd  = '0;
    if (busy) begin
      mem_we  = 4'b1111;
      mem_idx = init_cnt_q;
    end else if (wr_en) begin
      mem_we = lane_mask(bus.size, lane);
      case (bus.size)
        SZ_B:    mem_wd = {4{bus.data_in[7:0]}};
        SZ_H:    mem_wd = {2{bus.data_in[15:0]}};
        default: mem_wd = bus.data_in;
      endcase
    end
  end

  for (genvar b = 0; b < 4; b++) begin : g_bank
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (mem_we[b]) mem[mem_idx] <= mem_wd[8*b +: 8];
    end

    assign rd_word[8*b +: 8] = mem[word_idx];
  end

  dmem_load_align u_align (
    .word     (rd_word),
    .lane     (lane),
    .size     (bus.size),
    .sign_ext (bus.sign_ext),
    .result   (aligned)
  );

  assign bus.data_out = rd_en ? aligned : 32'h0;
  assign bus.misalign = misalign;
  assign bus.busy     = busy;

endmodule
